// File: rtl/dds_sweep_ctrl_if.sv
// Bundle of the sweep programme inputs and the DDS-facing/status outputs.
// No latency of its own; pure wiring between the sweep controller and its user.
// No backpressure: every signal is a level or a single-cycle pulse.
interface dds_sweep_ctrl_if #(
  parameter int DWELL_W = 16
);
  logic               start;
  logic               stop_req;
  logic [31:0]        f_start;
  logic [31:0]        f_stop;
  logic [31:0]        f_step;
  logic [DWELL_W-1:0] dwell;
  logic [1:0]         mode;
  logic [11:0]        p_word_in;
  logic [1:0]         wave_type_in;

  logic               dds_en;
  logic [31:0]        f_word;
  logic [11:0]        p_word;
  logic [1:0]         wave_type;
  logic               busy;
  logic               done;
  logic               wrap;

  // Side that programmes the sweep and observes the DDS controls.
  modport master (
    output start, stop_req, f_start, f_stop, f_step, dwell, mode, p_word_in, wave_type_in,
    input  dds_en, f_word, p_word, wave_type, busy, done, wrap
  );

  // Sweep controller side.
  modport slave (
    input  start, stop_req, f_start, f_stop, f_step, dwell, mode, p_word_in, wave_type_in,
    output dds_en, f_word, p_word, wave_type, busy, done, wrap
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep controller: steps a DDS tuning word from f_start to f_stop (single/saw/triangle).
// Latency: outputs registered; a start accepted in IDLE shows f_start on f_word the next cycle.
// No backpressure: start is ignored while busy, stop_req aborts to IDLE on the next edge.
module dds_sweep_ctrl #(
  parameter int DWELL_W = 16
) (
  input  logic             clk_dds,
  input  logic             rst,
  dds_sweep_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN_UP = 2'd1;
  localparam logic [1:0] S_RUN_DN = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  // Mode 2'b00 and the unused 2'b11 both behave as a single upward sweep.
  localparam logic [1:0] M_SAW = 2'b01;
  localparam logic [1:0] M_TRI = 2'b10;

  logic [1:0]         state_q;
  logic [31:0]        sh_start;
  logic [31:0]        sh_stop;
  logic [31:0]        sh_step;
  logic [DWELL_W-1:0] sh_dwell;
  logic [1:0]         sh_mode;
  logic [DWELL_W-1:0] dwell_cnt_q;

  logic [31:0]        f_word_q;
  logic [11:0]        p_word_q;
  logic [1:0]         wave_type_q;
  logic               dds_en_q;
  logic               busy_q;
  logic               done_q;
  logic               wrap_q;

  logic               accept;
  logic               expired;
  logic [32:0]        up_sum;
  logic [32:0]        dn_diff;
  logic [31:0]        up_next;
  logic [31:0]        dn_next;

  assign accept  = (state_q == S_IDLE) && bus.start && !bus.stop_req;
  assign expired = (dwell_cnt_q == sh_dwell);

  // Next up/down frequency, 33-bit so a carry or borrow clamps to the sweep limits.
  // When f_word sits on a limit these also give the turnaround point of the triangle.
  always_comb begin
    up_sum  = {1'b0, f_word_q} + {1'b0, sh_step};
    dn_diff = {1'b0, f_word_q} - {1'b0, sh_step};
    up_next = (up_sum > {1'b0, sh_stop}) ? sh_stop : up_sum[31:0];
    dn_next = (dn_diff[32] || (dn_diff[31:0] < sh_start)) ? sh_start : dn_diff[31:0];
  end

  // Capture the sweep programme when a start is accepted; held until the next accept.
  always_ff @(posedge clk_dds or negedge rst) begin
    if (!rst) begin
      sh_start    <= '0;
      sh_stop     <= '0;
      sh_step     <= '0;
      sh_dwell    <= '0;
      sh_mode     <= '0;
      p_word_q    <= '0;
      wave_type_q <= '0;
    end else if (accept) begin
      sh_start    <= bus.f_start;
      sh_stop     <= bus.f_stop;
      sh_step     <= bus.f_step;
      sh_dwell    <= bus.dwell;
      sh_mode     <= bus.mode;
      p_word_q    <= bus.p_word_in;
      wave_type_q <= bus.wave_type_in;
    end
  end

  // Sweep state machine, dwell counter and DDS/status outputs.
  always_ff @(posedge clk_dds or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      dwell_cnt_q <= '0;
      f_word_q    <= '0;
      dds_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (accept) begin
          f_word_q    <= bus.f_start;
          dds_en_q    <= 1'b1;
          busy_q      <= 1'b1;
          dwell_cnt_q <= '0;
          // A zero step or an empty/inverted range has nothing to sweep.
          if ((bus.f_step == 32'd0) || (bus.f_stop <= bus.f_start)) begin
            state_q <= S_HOLD;
          end else begin
            state_q <= S_RUN_UP;
          end
        end
      end else if (bus.stop_req) begin
        // Abort: silent return to IDLE, no done pulse.
        state_q     <= S_IDLE;
        dwell_cnt_q <= '0;
        f_word_q    <= '0;
        dds_en_q    <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          S_RUN_UP: begin
            if (!expired) begin
              dwell_cnt_q <= dwell_cnt_q + DWELL_W'(1);
            end else begin
              dwell_cnt_q <= '0;
              if (f_word_q < sh_stop) begin
                f_word_q <= up_next;
              end else if (sh_mode == M_SAW) begin
                f_word_q <= sh_start;
                wrap_q   <= 1'b1;
              end else if (sh_mode == M_TRI) begin
                state_q  <= S_RUN_DN;
                f_word_q <= dn_next;
              end else begin
                state_q  <= S_IDLE;
                f_word_q <= '0;
                dds_en_q <= 1'b0;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
              end
            end
          end
          S_RUN_DN: begin
            if (!expired) begin
              dwell_cnt_q <= dwell_cnt_q + DWELL_W'(1);
            end else begin
              dwell_cnt_q <= '0;
              if (f_word_q > sh_start) begin
                f_word_q <= dn_next;
              end else begin
                state_q  <= S_RUN_UP;
                f_word_q <= up_next;
                wrap_q   <= 1'b1;
              end
            end
          end
          default: begin
            // HOLD: parked on f_start with the counter idle until stop_req.
            dwell_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign bus.f_word    = f_word_q;
  assign bus.p_word    = p_word_q;
  assign bus.wave_type = wave_type_q;
  assign bus.dds_en    = dds_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.wrap      = wrap_q;

endmodule
